// File: rtl/dmem_arbiter.sv
// Data-memory arbiter between the single-cycle CPU and a DMA/debug loader.
// CPU has priority; a starvation counter forces one DMA slot after MAX_WAIT losses.
//
// Ports:
//   clk, clrn                         clock, async active-low reset
//   cpu_req/we/addr/wdata, cpu_rdata  CPU load/store side (0-cycle access)
//   cpu_stall                         CPU must hold PC / suppress write-back
//   dma_valid/we/addr/wdata           DMA request, held until dma_ready
//   dma_ready                         DMA granted this cycle
//   dma_rdata, dma_rvalid             registered DMA read response
//   mem_we/addr/wdata, mem_rdata      single-port memory (sync write, comb read)
module dmem_arbiter #(
   parameter int AW       = 32,
   parameter int DW       = 32,
   parameter int MAX_WAIT = 4
) (
   input  logic          clk,
   input  logic          clrn,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic [DW-1:0] cpu_rdata,
   output logic          cpu_stall,
   input  logic          dma_valid,
   input  logic          dma_we,
   input  logic [AW-1:0] dma_addr,
   input  logic [DW-1:0] dma_wdata,
   output logic          dma_ready,
   output logic [DW-1:0] dma_rdata,
   output logic          dma_rvalid,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
);

   localparam int CW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
   localparam logic [CW-1:0] MAXC  = CW'(MAX_WAIT);
   localparam logic [CW-1:0] MAXM1 = CW'(MAX_WAIT - 1);

   typedef enum logic {
      NORMAL,
      FORCE
   } state_t;

   state_t        state;
   state_t        state_nx;
   logic [CW-1:0] wait_cnt;
   logic [CW-1:0] wait_nx;
   logic          cpu_gnt;
   logic          dma_gnt;
   logic [DW-1:0] dma_rdata_q;
   logic          dma_rvalid_q;

   // Grants are held off while clrn is low so nothing reaches memory in reset.
   always_comb begin
      cpu_gnt   = 1'b0;
      dma_gnt   = 1'b0;
      cpu_stall = 1'b0;
      state_nx  = state;
      wait_nx   = wait_cnt;
      if (clrn) begin
         unique case (state)
            NORMAL: begin
               cpu_gnt = cpu_req;
               dma_gnt = ~cpu_req & dma_valid;
               if (cpu_req & dma_valid) begin
                  // The loss that reaches MAX_WAIT books the next cycle for DMA.
                  if (wait_cnt >= MAXM1) begin
                     wait_nx  = MAXC;
                     state_nx = FORCE;
                  end else begin
                     wait_nx = wait_cnt + 1'b1;
                  end
               end else begin
                  wait_nx = '0;
               end
            end
            FORCE: begin
               // A withdrawn DMA request leaves the slot to the CPU, unstalled.
               dma_gnt   = dma_valid;
               cpu_stall = cpu_req & dma_valid;
               cpu_gnt   = cpu_req & ~dma_valid;
               state_nx  = NORMAL;
               wait_nx   = '0;
            end
         endcase
      end
   end

   always_comb begin
      if (dma_gnt) begin
         mem_we    = dma_we;
         mem_addr  = dma_addr;
         mem_wdata = dma_wdata;
      end else begin
         mem_we    = cpu_gnt & cpu_we;
         mem_addr  = cpu_addr;
         mem_wdata = cpu_wdata;
      end
   end

   assign dma_ready  = dma_gnt;
   assign cpu_rdata  = mem_rdata;
   assign dma_rdata  = dma_rdata_q;
   assign dma_rvalid = dma_rvalid_q;

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         state        <= NORMAL;
         wait_cnt     <= '0;
         dma_rdata_q  <= '0;
         dma_rvalid_q <= 1'b0;
      end else begin
         state        <= state_nx;
         wait_cnt     <= wait_nx;
         dma_rvalid_q <= dma_gnt & ~dma_we;
         if (dma_gnt & ~dma_we) begin
            dma_rdata_q <= mem_rdata;
         end
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios then random traffic,
// against a loss-counting model and a reference memory image.
module tb_dmem_arbiter;

   localparam int MW = 4;

   logic        clk;
   logic        clrn;
   logic        cpu_req;
   logic        cpu_we;
   logic [31:0] cpu_addr;
   logic [31:0] cpu_wdata;
   logic [31:0] cpu_rdata;
   logic        cpu_stall;
   logic        dma_valid;
   logic        dma_we;
   logic [31:0] dma_addr;
   logic [31:0] dma_wdata;
   logic        dma_ready;
   logic [31:0] dma_rdata;
   logic        dma_rvalid;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   logic [31:0] mem [64];
   logic [31:0] ref_mem [64];

   int n_cmp;
   int n_err;

   // model state
   int          losses;
   bit          pend_rv;
   logic [31:0] pend_rd;

   dmem_arbiter #(
      .AW(32), .DW(32), .MAX_WAIT(MW)
   ) dut (
      .clk(clk), .clrn(clrn),
      .cpu_req(cpu_req), .cpu_we(cpu_we),
      .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
      .dma_valid(dma_valid), .dma_we(dma_we),
      .dma_addr(dma_addr), .dma_wdata(dma_wdata),
      .dma_ready(dma_ready), .dma_rdata(dma_rdata),
      .dma_rvalid(dma_rvalid),
      .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   assign mem_rdata = mem[mem_addr[7:2]];

   always @(posedge clk) begin
      if (mem_we) mem[mem_addr[7:2]] <= mem_wdata;
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      losses  = 0;
      pend_rv = 1'b0;
      pend_rd = '0;
   endtask

   // One clock cycle: drive at negedge, check at +1, advance model.
   task automatic step(input logic creq, input logic cwe,
                       input logic [31:0] caddr, input logic [31:0] cwd,
                       input logic dv, input logic dwe,
                       input logic [31:0] daddr, input logic [31:0] dwd,
                       output bit granted);
      bit          forced;
      bit          e_dgnt;
      bit          e_stall;
      bit          cpu_acc;
      bit          e_we;
      logic [31:0] e_addr;
      logic [31:0] e_wd;
      @(negedge clk);
      cpu_req   = creq;
      cpu_we    = cwe;
      cpu_addr  = caddr;
      cpu_wdata = cwd;
      dma_valid = dv;
      dma_we    = dwe;
      dma_addr  = daddr;
      dma_wdata = dwd;
      #1;
      forced  = (losses == MW) && dv;
      e_dgnt  = dv && (forced || !creq);
      e_stall = forced && creq;
      cpu_acc = creq && !e_stall;
      e_we    = e_dgnt ? dwe : (cpu_acc && cwe);
      e_addr  = e_dgnt ? daddr : caddr;
      e_wd    = e_dgnt ? dwd : cwd;
      chk("dma_ready", 32'(dma_ready), 32'(e_dgnt));
      chk("cpu_stall", 32'(cpu_stall), 32'(e_stall));
      chk("mem_we", 32'(mem_we), 32'(e_we));
      chk("dma_rvalid", 32'(dma_rvalid), 32'(pend_rv));
      if (pend_rv) chk("dma_rdata", dma_rdata, pend_rd);
      if (e_we) begin
         chk("mem_addr", mem_addr, e_addr);
         chk("mem_wdata", mem_wdata, e_wd);
      end
      if (cpu_acc && !cwe) chk("cpu_rdata", cpu_rdata, ref_mem[caddr[7:2]]);
      pend_rv = e_dgnt && !dwe;
      if (pend_rv) pend_rd = ref_mem[daddr[7:2]];
      if (e_we) ref_mem[e_addr[7:2]] = e_wd;
      if (losses == MW) losses = 0;
      else if (creq && dv) losses++;
      else losses = 0;
      granted = e_dgnt;
   endtask

   initial begin
      bit          g;
      logic        dv;
      logic        dwe;
      logic [31:0] da;
      logic [31:0] dd;
      n_cmp = 0;
      n_err = 0;
      for (int i = 0; i < 64; i++) begin
         mem[i]     = '0;
         ref_mem[i] = '0;
      end
      model_reset();

      // reset with requests active
      clrn      = 1'b0;
      cpu_req   = 1'b1;
      cpu_we    = 1'b1;
      cpu_addr  = 32'h10;
      cpu_wdata = 32'h1234;
      dma_valid = 1'b1;
      dma_we    = 1'b1;
      dma_addr  = 32'h14;
      dma_wdata = 32'h5678;
      @(posedge clk);
      #1;
      chk("rst mem_we", 32'(mem_we), 32'h0);
      chk("rst dma_ready", 32'(dma_ready), 32'h0);
      chk("rst cpu_stall", 32'(cpu_stall), 32'h0);
      chk("rst dma_rvalid", 32'(dma_rvalid), 32'h0);
      chk("rst dma_rdata", dma_rdata, 32'h0);
      @(negedge clk);
      clrn = 1'b1;

      // CPU store then load
      step(1, 1, 32'h10, 32'hDEADBEEF, 0, 0, 0, 0, g);
      chk("t2 sw mem_we", 32'(mem_we), 32'h1);
      step(1, 0, 32'h10, 32'h0, 0, 0, 0, 0, g);
      chk("t2 lw data", cpu_rdata, 32'hDEADBEEF);

      // DMA read in an idle slot
      step(0, 0, 0, 0, 1, 0, 32'h10, 0, g);
      chk("t3 ready", 32'(dma_ready), 32'h1);
      step(0, 0, 0, 0, 0, 0, 0, 0, g);
      chk("t3 rvalid", 32'(dma_rvalid), 32'h1);
      chk("t3 rdata", dma_rdata, 32'hDEADBEEF);
      step(0, 0, 0, 0, 0, 0, 0, 0, g);
      chk("t3 rvalid off", 32'(dma_rvalid), 32'h0);

      // starvation pattern, repeats every MW+1 cycles
      for (int i = 0; i < 2 * (MW + 1); i++) begin
         step(1, 0, 32'h0, 0, 1, 0, 32'h10, 0, g);
         chk("t4 ready", 32'(dma_ready), 32'((i % (MW + 1)) == MW));
         chk("t4 stall", 32'(cpu_stall), 32'((i % (MW + 1)) == MW));
      end

      // stalled CPU store must not land
      for (int i = 0; i < MW; i++) step(1, 0, 32'h20, 0, 1, 1, 32'h24, 32'h2, g);
      step(1, 1, 32'h20, 32'h1, 1, 1, 32'h24, 32'h2, g);
      chk("t5 forced", 32'(cpu_stall), 32'h1);
      step(1, 1, 32'h20, 32'h1, 0, 0, 0, 0, g);
      chk("t5 0x20 kept", mem[8], 32'h0);
      chk("t5 0x24 written", mem[9], 32'h2);
      step(1, 0, 32'h20, 0, 0, 0, 0, 0, g);
      chk("t5 retry data", cpu_rdata, 32'h1);

      // reset during the forced slot
      for (int i = 0; i < MW; i++) step(1, 0, 32'h0, 0, 1, 1, 32'h30, 32'h55, g);
      @(negedge clk);
      clrn = 1'b0;
      #1;
      chk("t6 mem_we", 32'(mem_we), 32'h0);
      chk("t6 ready", 32'(dma_ready), 32'h0);
      @(posedge clk);
      #1;
      chk("t6 rvalid", 32'(dma_rvalid), 32'h0);
      chk("t6 no write", mem[12], 32'h0);
      clrn = 1'b1;
      model_reset();
      step(1, 0, 32'h0, 0, 1, 1, 32'h30, 32'h55, g);
      chk("t6 cpu first", 32'(dma_ready), 32'h0);
      step(0, 0, 0, 0, 1, 1, 32'h30, 32'h55, g);

      // random traffic with a protocol-respecting DMA master
      dv  = 1'b0;
      dwe = 1'b0;
      da  = '0;
      dd  = '0;
      for (int i = 0; i < 400; i++) begin
         logic        creq;
         logic        cwe;
         logic [31:0] ca;
         logic [31:0] cd;
         if (!dv && ($urandom_range(0, 1) == 1)) begin
            dv  = 1'b1;
            dwe = 1'($urandom_range(0, 1));
            da  = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
            dd  = $urandom;
         end
         creq = ($urandom_range(0, 9) < 7);
         cwe  = 1'($urandom_range(0, 1));
         ca   = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
         cd   = $urandom;
         step(creq, cwe, ca, cd, dv, dwe, da, dd, g);
         if (g) dv = 1'b0;
      end
      step(0, 0, 0, 0, 0, 0, 0, 0, g);
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         chk("final mem", mem[i], ref_mem[i]);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
